// File: rtl/dds_signal_generator.sv
// DDS waveform core: phase accumulator with sine ROM lookup or computed saw/square/triangle,
// amplitude scaling, sample-rate divider and shadowed configuration with wrap-synchronous commit.
module dds_signal_generator #(
  parameter int ACC_W  = 32,
  parameter int LUT_AW = 9,
  parameter int DATA_W = 8,
  parameter int AMP_W  = 4,
  parameter int DIV_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [2:0]               cfg_addr,
  input  logic [ACC_W-1:0]         cfg_data,
  output logic [LUT_AW-1:0]        rom_addr,
  input  logic [DATA_W-1:0]        rom_data,
  output logic                     sample_valid,
  output logic [DATA_W+AMP_W-1:0]  wave_out,
  output logic                     commit_pending
);

  localparam int                OUT_W     = DATA_W + AMP_W;
  localparam logic [ACC_W-1:0]  FTW_RST   = ACC_W'(1);
  localparam logic [AMP_W-1:0]  AMP_RST   = AMP_W'(1);
  localparam logic [LUT_AW-1:0] DUTY_RST  = LUT_AW'(1) << (LUT_AW - 1);
  localparam logic [DATA_W-1:0] FULL      = '1;
  localparam logic [1:0]        WAVE_SINE = 2'd0;
  localparam logic [1:0]        WAVE_SAW  = 2'd1;
  localparam logic [1:0]        WAVE_SQR  = 2'd2;

  logic [ACC_W-1:0]  r_sh_ftw, r_sh_phase, r_ftw, r_phase;
  logic [AMP_W-1:0]  r_sh_amp, r_amp;
  logic [1:0]        r_sh_wave, r_wave;
  logic [DIV_W-1:0]  r_sh_div, r_div;
  logic [LUT_AW-1:0] r_sh_duty, r_duty;
  logic              r_pending, r_pend_clr;
  logic [ACC_W-1:0]  r_acc;
  logic [DIV_W-1:0]  r_cnt;

  logic              r_v1, r_v2, r_sample_valid;
  logic [LUT_AW-1:0] r_rom_addr, r_p2;
  logic [1:0]        r_wave1, r_wave2;
  logic [LUT_AW-1:0] r_duty1, r_duty2;
  logic [AMP_W-1:0]  r_amp1, r_amp2;
  logic [OUT_W-1:0]  r_wave_out;

  logic              w_tick, w_wr, w_wrap, w_apply_imm, w_apply_def, w_apply, w_clr;
  logic [ACC_W:0]    w_sum;
  logic [LUT_AW-1:0] w_idx;
  logic [DATA_W-1:0] w_sample;
  logic [OUT_W-1:0]  w_prod;

  assign w_tick      = (r_cnt == '0);
  assign w_wr        = cfg_valid && !r_pending;
  assign w_sum       = {1'b0, r_acc} + {1'b0, r_ftw};
  assign w_wrap      = w_tick && w_sum[ACC_W];
  assign w_idx       = LUT_AW'((r_acc + r_phase) >> (ACC_W - LUT_AW));
  assign w_apply_imm = w_wr && (cfg_addr == 3'd6) && !cfg_data[0];
  assign w_apply_def = r_pending && w_wrap;
  assign w_apply     = w_apply_imm || w_apply_def;
  assign w_clr       = w_apply_imm ? cfg_data[1] : r_pend_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_ftw   <= FTW_RST;
      r_sh_phase <= '0;
      r_sh_amp   <= AMP_RST;
      r_sh_wave  <= WAVE_SINE;
      r_sh_div   <= '0;
      r_sh_duty  <= DUTY_RST;
      r_pending  <= 1'b0;
      r_pend_clr <= 1'b0;
    end else begin
      if (w_wr) begin
        case (cfg_addr)
          3'd0: r_sh_ftw   <= cfg_data;
          3'd1: r_sh_phase <= cfg_data;
          3'd2: r_sh_amp   <= cfg_data[AMP_W-1:0];
          3'd3: r_sh_wave  <= cfg_data[1:0];
          3'd4: r_sh_div   <= cfg_data[DIV_W-1:0];
          3'd5: r_sh_duty  <= cfg_data[LUT_AW-1:0];
          3'd6: begin
            if (cfg_data[0]) begin
              r_pending  <= 1'b1;
              r_pend_clr <= cfg_data[1];
            end
          end
          default: ;
        endcase
      end
      if (w_apply_def) r_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ftw   <= FTW_RST;
      r_phase <= '0;
      r_amp   <= AMP_RST;
      r_wave  <= WAVE_SINE;
      r_div   <= '0;
      r_duty  <= DUTY_RST;
    end else if (w_apply) begin
      r_ftw   <= r_sh_ftw;
      r_phase <= r_sh_phase;
      r_amp   <= r_sh_amp;
      r_wave  <= r_sh_wave;
      r_div   <= r_sh_div;
      r_duty  <= r_sh_duty;
    end
  end

  // A clear on apply wins over the add of the same cycle; the add always uses the old FTW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else begin
      if (w_tick) r_cnt <= r_div;
      else        r_cnt <= r_cnt - DIV_W'(1);
      if (w_apply && w_clr) r_acc <= '0;
      else if (w_tick)      r_acc <= w_sum[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1           <= 1'b0;
      r_v2           <= 1'b0;
      r_sample_valid <= 1'b0;
      r_rom_addr     <= '0;
      r_p2           <= '0;
      r_wave1        <= '0;
      r_wave2        <= '0;
      r_duty1        <= '0;
      r_duty2        <= '0;
      r_amp1         <= '0;
      r_amp2         <= '0;
      r_wave_out     <= '0;
    end else begin
      r_v1 <= w_tick;
      if (w_tick) begin
        r_rom_addr <= w_idx;
        r_wave1    <= r_wave;
        r_duty1    <= r_duty;
        r_amp1     <= r_amp;
      end
      r_v2 <= r_v1;
      if (r_v1) begin
        r_p2    <= r_rom_addr;
        r_wave2 <= r_wave1;
        r_duty2 <= r_duty1;
        r_amp2  <= r_amp1;
      end
      r_sample_valid <= r_v2;
      if (r_v2) r_wave_out <= w_prod;
    end
  end

  // Computed waves are held one extra stage so they line up with the ROM read.
  always_comb begin
    w_sample = '0;
    case (r_wave2)
      WAVE_SINE: w_sample = rom_data;
      WAVE_SAW:  w_sample = r_p2[LUT_AW-1 -: DATA_W];
      WAVE_SQR:  w_sample = (r_p2 < r_duty2) ? FULL : '0;
      default:   w_sample = r_p2[LUT_AW-1] ? ~r_p2[LUT_AW-2 -: DATA_W] : r_p2[LUT_AW-2 -: DATA_W];
    endcase
  end

  assign w_prod         = OUT_W'(w_sample) * OUT_W'(r_amp2);
  assign cfg_ready      = !r_pending;
  assign commit_pending = r_pending;
  assign rom_addr       = r_rom_addr;
  assign sample_valid   = r_sample_valid;
  assign wave_out       = r_wave_out;

endmodule
